traffic_phase_ctrl: RTL and testbench

- Phase sequencer for the two-way intersection: main road and side road.
- Generates its own 1 s tick from clk100M and times each phase with a per-phase seconds counter.
- The seconds counter restarts whenever the phase changes.
- Drives both light heads plus a countdown value for the display, and supports pause, pedestrian early-exit and night flashing mode.

---
 rtl/traffic_phase_ctrl_if.sv | 24 ++
 rtl/traffic_phase_ctrl.sv | 157 +++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/traffic_phase_ctrl_if.sv
// Signal bundle between the intersection phase sequencer and its environment:
// operator/pedestrian controls in, light heads and display values out.
interface traffic_phase_ctrl_if;
  logic       pause;
  logic       ped_req;
  logic       night;
  logic [2:0] main_ryg;
  logic [2:0] side_ryg;
  logic [4:0] remain;
  logic [2:0] phase;
  logic       tick;

  // Environment side: drives the controls, observes the lights.
  modport master (
    output pause, ped_req, night,
    input  main_ryg, side_ryg, remain, phase, tick
  );

  // Sequencer side.
  modport slave (
    input  pause, ped_req, night,
    output main_ryg, side_ryg, remain, phase, tick
  );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Two-way intersection phase sequencer (main road / side road).
// Derives a 1 s tick from the system clock, times each phase with a seconds
// counter that restarts on every phase change, and supports pause, an early
// pedestrian exit from main green, and a flashing-yellow night mode.
module traffic_phase_ctrl #(
  parameter int TICK_DIV     = 100000000,
  parameter int MAIN_GREEN_T = 30,
  parameter int SIDE_GREEN_T = 20,
  parameter int YELLOW_T     = 3,
  parameter int ALLRED_T     = 1,
  parameter int MIN_GREEN    = 10
) (
  input logic                 clk100M,
  input logic                 rst,
  traffic_phase_ctrl_if.slave bus
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [4:0] PED_MIN = 5'(MIN_GREEN - 1);

  typedef enum logic [2:0] {
    MG  = 3'd0,
    MY  = 3'd1,
    AR1 = 3'd2,
    SG  = 3'd3,
    SY  = 3'd4,
    AR2 = 3'd5,
    FL  = 3'd6
  } state_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       sec_cnt;
  logic [4:0]       dur;
  logic             ped_pend;
  logic             flash;
  logic             tick_w;
  logic             changing;

  // Tick fires on the last divider count unless paused (divider frozen).
  assign tick_w   = !bus.pause && (div_cnt == DIV_LAST);
  assign changing = (state_d != state_q);

  // Duration of the current phase in seconds.
  always_comb begin
    dur = 5'd0;
    case (state_q)
      MG:       dur = 5'(MAIN_GREEN_T);
      MY, SY:   dur = 5'(YELLOW_T);
      AR1, AR2: dur = 5'(ALLRED_T);
      SG:       dur = 5'(SIDE_GREEN_T);
      default:  dur = 5'd0;
    endcase
  end

  // Next-state: night overrides everything; expiry and pedestrian exit only on a tick.
  always_comb begin
    state_d = state_q;
    if (bus.night) begin
      state_d = FL;
    end else if (state_q == FL) begin
      state_d = AR2;
    end else if (tick_w) begin
      if (sec_cnt == dur - 5'd1) begin
        case (state_q)
          MG:      state_d = MY;
          MY:      state_d = AR1;
          AR1:     state_d = SG;
          SG:      state_d = SY;
          SY:      state_d = AR2;
          AR2:     state_d = MG;
          default: state_d = MG;
        endcase
      end else if (state_q == MG && ped_pend && sec_cnt >= PED_MIN) begin
        state_d = MY;
      end
    end
  end

  // Moore decode of the light heads and display values.
  always_comb begin
    bus.main_ryg = RED;
    bus.side_ryg = RED;
    bus.remain   = dur - sec_cnt;
    case (state_q)
      MG: bus.main_ryg = GRN;
      MY: bus.main_ryg = YEL;
      SG: bus.side_ryg = GRN;
      SY: bus.side_ryg = YEL;
      FL: begin
        bus.main_ryg = flash ? YEL : OFF;
        bus.side_ryg = flash ? YEL : OFF;
        bus.remain   = 5'd0;
      end
      default: ;
    endcase
  end

  assign bus.phase = state_q;
  assign bus.tick  = tick_w;

  // Free-running 1 s divider, held while paused.
  always_ff @(posedge clk100M or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (!bus.pause) begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end
  end

  // Phase register.
  always_ff @(posedge clk100M or negedge rst) begin
    if (!rst) state_q <= MG;
    else      state_q <= state_d;
  end

  // Seconds in the current phase: restarts on a phase change, counts ticks otherwise.
  always_ff @(posedge clk100M or negedge rst) begin
    if (!rst) begin
      sec_cnt <= 5'd0;
    end else if (changing) begin
      sec_cnt <= 5'd0;
    end else if (tick_w && state_q != FL) begin
      sec_cnt <= sec_cnt + 5'd1;
    end
  end

  // Flash phase: starts dark on entering night mode and toggles each second.
  always_ff @(posedge clk100M or negedge rst) begin
    if (!rst) begin
      flash <= 1'b0;
    end else if (state_d != FL || state_q != FL) begin
      flash <= 1'b0;
    end else if (tick_w) begin
      flash <= ~flash;
    end
  end

  // Pending pedestrian request; the MG->MY or FL entry consumes it, even if
  // a request arrives in that same cycle.
  always_ff @(posedge clk100M or negedge rst) begin
    if (!rst) begin
      ped_pend <= 1'b0;
    end else if (changing && (state_d == MY || state_d == FL)) begin
      ped_pend <= 1'b0;
    end else if (bus.ped_req && state_q != FL) begin
      ped_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with a 4-cycle tick.
module tb_traffic_phase_ctrl;

  logic clk100M = 1'b0;
  logic rst     = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  traffic_phase_ctrl_if bus ();

  traffic_phase_ctrl #(
    .TICK_DIV     (4),
    .MAIN_GREEN_T (30),
    .SIDE_GREEN_T (20),
    .YELLOW_T     (3),
    .ALLRED_T     (1),
    .MIN_GREEN    (10)
  ) dut (
    .clk100M (clk100M),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk100M = ~clk100M;

  typedef struct {
    int         cyc;
    logic       tk;
    logic [2:0] m;
    logic [2:0] s;
    logic [4:0] rem;
    logic [2:0] ph;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk100M);
  endtask

  task automatic do_reset();
    @(negedge clk100M);
    rst         = 1'b0;
    bus.pause   = 1'b0;
    bus.ped_req = 1'b0;
    bus.night   = 1'b0;
    step(2);
    rst = 1'b1;
  endtask

  task automatic chk_out(input string nm, input logic [2:0] m, input logic [2:0] s,
                         input logic [4:0] rem, input logic [2:0] ph);
    chk({nm, "_main"},   32'(bus.main_ryg), 32'(m));
    chk({nm, "_side"},   32'(bus.side_ryg), 32'(s));
    chk({nm, "_remain"}, 32'(bus.remain),   32'(rem));
    chk({nm, "_phase"},  32'(bus.phase),    32'(ph));
  endtask

  // Safety: outside night mode at least one head shows red; tick never lasts two cycles.
  logic tick_prev = 1'b0;
  always @(negedge clk100M) begin
    if (rst) begin
      checks++;
      if (bus.phase != 3'd6 && bus.main_ryg != 3'b100 && bus.side_ryg != 3'b100) begin
        errors++;
        $display("FAIL safety main %b side %b phase %0d", bus.main_ryg, bus.side_ryg, bus.phase);
      end
      if (tick_prev && bus.tick) begin
        errors++;
        $display("FAIL tick_width tick high on consecutive cycles");
      end
    end
    tick_prev = bus.tick;
  end

  int ticks_seen;

  initial begin
    bus.pause   = 1'b0;
    bus.ped_req = 1'b0;
    bus.night   = 1'b0;

    // Cumulative cycle counts after reset release are noted per row.
    tbl[0]  = '{0,   1'b0, 3'b001, 3'b100, 5'd30, 3'd0}; // 0
    tbl[1]  = '{3,   1'b1, 3'b001, 3'b100, 5'd30, 3'd0}; // 3: first tick
    tbl[2]  = '{1,   1'b0, 3'b001, 3'b100, 5'd29, 3'd0}; // 4
    tbl[3]  = '{112, 1'b0, 3'b001, 3'b100, 5'd1,  3'd0}; // 116
    tbl[4]  = '{4,   1'b0, 3'b010, 3'b100, 5'd3,  3'd1}; // 120 MY
    tbl[5]  = '{12,  1'b0, 3'b100, 3'b100, 5'd1,  3'd2}; // 132 AR1
    tbl[6]  = '{4,   1'b0, 3'b100, 3'b001, 5'd20, 3'd3}; // 136 SG
    tbl[7]  = '{80,  1'b0, 3'b100, 3'b010, 5'd3,  3'd4}; // 216 SY
    tbl[8]  = '{12,  1'b0, 3'b100, 3'b100, 5'd1,  3'd5}; // 228 AR2
    tbl[9]  = '{4,   1'b0, 3'b001, 3'b100, 5'd30, 3'd0}; // 232 MG again
    tbl[10] = '{3,   1'b1, 3'b001, 3'b100, 5'd30, 3'd0}; // 235

    // Reset state while rst is held low
    step(1);
    chk_out("rst_hold", 3'b001, 3'b100, 5'd30, 3'd0);
    chk("rst_tick", 32'(bus.tick), 32'd0);
    step(1);
    rst = 1'b1;

    // Full normal cycle
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].cyc);
      chk_out($sformatf("cycle%0d", i), tbl[i].m, tbl[i].s, tbl[i].rem, tbl[i].ph);
      chk($sformatf("cycle%0d_tick", i), 32'(bus.tick), 32'(tbl[i].tk));
    end

    // Pedestrian pulse at second 2: leaves MG on the tick ending second 9
    do_reset();
    step(8);
    bus.ped_req = 1'b1;
    step(1);
    bus.ped_req = 1'b0;
    step(27);
    chk_out("ped_early_hold", 3'b001, 3'b100, 5'd21, 3'd0);
    step(4);
    chk_out("ped_early_exit", 3'b010, 3'b100, 5'd3, 3'd1);

    // Pedestrian pulse at second 15: leaves MG on the next tick; a request
    // coincident with that transition is consumed
    do_reset();
    step(60);
    bus.ped_req = 1'b1;
    step(1);
    bus.ped_req = 1'b0;
    step(2);
    chk_out("ped_late_hold", 3'b001, 3'b100, 5'd15, 3'd0);
    chk("ped_late_tick", 32'(bus.tick), 32'd1);
    bus.ped_req = 1'b1;
    step(1);
    bus.ped_req = 1'b0;
    chk_out("ped_late_exit", 3'b010, 3'b100, 5'd3, 3'd1);
    step(112);
    chk_out("ped_next_mg", 3'b001, 3'b100, 5'd30, 3'd0);
    step(40);
    chk_out("ped_consumed", 3'b001, 3'b100, 5'd20, 3'd0);

    // Pause for 50 cycles in SG freezes everything
    do_reset();
    step(156);
    chk_out("pause_before", 3'b100, 3'b001, 5'd15, 3'd3);
    bus.pause  = 1'b1;
    ticks_seen = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (bus.tick) ticks_seen++;
    end
    chk("pause_ticks", 32'(ticks_seen), 32'd0);
    chk_out("pause_frozen", 3'b100, 3'b001, 5'd15, 3'd3);
    bus.pause = 1'b0;
    step(4);
    chk_out("pause_resume", 3'b100, 3'b001, 5'd14, 3'd3);

    // Night mode entered from SY, flashing, then exit via AR2
    do_reset();
    step(220);
    chk_out("night_pre", 3'b100, 3'b010, 5'd2, 3'd4);
    bus.night = 1'b1;
    step(1);
    chk_out("night_enter", 3'b000, 3'b000, 5'd0, 3'd6);
    step(3);
    chk_out("night_flash_on", 3'b010, 3'b010, 5'd0, 3'd6);
    step(4);
    chk_out("night_flash_off", 3'b000, 3'b000, 5'd0, 3'd6);
    bus.night = 1'b0;
    step(1);
    chk_out("night_exit_ar2", 3'b100, 3'b100, 5'd1, 3'd5);
    step(3);
    chk_out("night_back_mg", 3'b001, 3'b100, 5'd30, 3'd0);

    // Asynchronous reset in SG with remain 7 also drops a pending request
    do_reset();
    step(180);
    bus.ped_req = 1'b1;
    step(1);
    bus.ped_req = 1'b0;
    step(7);
    chk_out("mid_sg", 3'b100, 3'b001, 5'd7, 3'd3);
    #2;
    rst = 1'b0;
    #1;
    chk_out("async_rst", 3'b001, 3'b100, 5'd30, 3'd0);
    step(1);
    rst = 1'b1;
    step(40);
    chk_out("rst_ped_cleared", 3'b001, 3'b100, 5'd20, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
